fp_mul_seq: RTL and testbench
=============================

# fp_mul_seq

Sequential IEEE 754 single-precision multiplier with valid/ready handshakes on both sides. It computes the product as 24 shift-and-add iterations, one multiplier bit per cycle, then one normalise/round cycle. The division path needs the inverse operation for its multiply steps. This block is the area-lean multiply used for quotient × divisor check-back and for time-multiplexed iteration steps, where a full-width combinational multiplier is too large.

## Interface
- No parameters. Width is fixed at 32-bit binary32.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands a/b valid
- in_ready  out  1  block can accept operands; high only in IDLE
- a  in  32  multiplicand, binary32
- b  in  32  multiplier, binary32
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  downstream accepts result
- res  out  32  product, binary32
- exception  out  1  either operand had exponent 8'hFF
- overflow  out  1  result exponent ≥ 255
- underflow  out  1  result exponent ≤ 0, non-zero product
- busy  out  1  high in MUL, NORM and DONE

## Operation
- States are IDLE, MUL, NORM and DONE. Reset forces IDLE.
- IDLE: in_ready=1. If in_valid, then on the clock edge:
  - latch sign = a[31]^b[31].
  - latch ea, eb.
  - latch ma = {hidden, a[22:0]} and mb = {hidden, b[22:0]}. hidden = |exp.
  - clear the 48-bit accumulator P and the 5-bit counter.
  - go to MUL.
- MUL: each cycle consumes mb[0].
  - P = (P >> 1) with the top 25 bits replaced by {carry, P[47:24] + (mb[0] ? ma : 0)}.
  - mb >>= 1, counter += 1.
  - After 24 iterations (counter == 23 on the edge), go to NORM.
- NORM: one cycle.
  - norm = P[47]. Pn = norm ? P : P << 1.
  - round = Pn[23] & (|Pn[22:0]).
  - mant = Pn[46:24] + round. A carry out of mant sets mant = 0 and adds 1 to the exponent.
  - E = ea + eb − 127 + norm + carry, computed signed in 10 bits.
  - Go to DONE.
- Result priority, latched in NORM:
  1. exception (ea==255 or eb==255): res = 32'h0, exception = 1.
  2. zero (either operand has exp 0 and mantissa 0): res = {sign, 31'h0}.
  3. overflow (E ≥ 255): res = {sign, 8'hFF, 23'h0}, overflow = 1.
  4. underflow (E ≤ 0): res = {sign, 31'h0}, underflow = 1. Flush-to-zero; no subnormal outputs.
  5. otherwise: res = {sign, E[7:0], mant}.
- Flags are mutually exclusive. Zero suppresses overflow and underflow.
- Subnormal inputs use hidden bit 0 with the exponent field as stored. They are not pre-normalised.
- DONE: out_valid=1; res and flags are stable. When out_ready is high, return to IDLE.
- Simultaneous events: in DONE, in_ready=0. New operands are only accepted in the cycle after out_valid drops, so there is no same-cycle pass-through.
- In_valid outside IDLE is ignored. a/b need only be stable on the accepting edge.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, res=0, exception=0, overflow=0, underflow=0. State=IDLE, P=0, counter=0.
- Reset is asynchronous and effective mid-operation: any state returns to IDLE immediately, the result is discarded and outputs take reset values.
- Latency: operands are accepted at edge T0. MUL occupies T0..T24 (24 edges). NORM edge is T25. out_valid is high from after T25.
- Result is first observable 25 cycles after acceptance, 26 edges from acceptance to the IDLE-capable edge when out_ready is high.
- Throughput: one product per 27 cycles with out_ready tied high (accept, 24 MUL, NORM, DONE).
- Backpressure: out_valid, res and flags are held unchanged for any number of cycles while out_ready=0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Basic: a=32'h4000_0000 (2.0), b=32'h4040_0000 (3.0) -> res=32'h40C0_0000 with no flags. out_valid rises 25 cycles after the accept edge.
- Normalise and sign: a=32'h3FC0_0000 (1.5), b=32'hBFC0_0000 (−1.5) -> res=32'hC010_0000 (−2.25).
- Exception, zero and sign:
  - a=32'h7F80_0000, b=32'h3F80_0000 -> res=0, exception=1.
  - a=32'h8000_0000, b=32'h4000_0000 -> res=32'h8000_0000, no flags.
- Overflow and underflow:
  - a=b=32'h7F00_0000 -> res=32'h7F80_0000, overflow=1.
  - a=b=32'h0080_0000 -> res=32'h0000_0000, underflow=1.
- Handshake: hold out_ready=0 for 10 cycles -> res, flags and out_valid are stable, and in_valid pulses are ignored. Release out_ready -> in_ready returns next cycle. Back-to-back transactions with out_ready=1 complete at 27-cycle spacing.
- Reset mid-operation: assert rst at MUL iteration 12 -> outputs are at reset values immediately after rst. After release, a fresh 2.0×3.0 yields 32'h40C0_0000 with normal latency.

Source files
------------

// File: rtl/fp_mul_seq_if.sv
// fp_mul_seq_if
// Handshake and data bundle for the sequential binary32 multiplier.
//   master : the requester. It drives the operands (in_valid, a, b) and
//            out_ready, and observes the result side.
//   slave  : the multiplier. It drives in_ready, out_valid, res, the
//            exception/overflow/underflow flags and busy.
interface fp_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        exception;
  logic        overflow;
  logic        underflow;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, res, exception, overflow, underflow, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, res, exception, overflow, underflow, busy
  );
endinterface

// File: rtl/fp_mul_seq.sv
// fp_mul_seq
// Area-lean IEEE 754 binary32 multiplier. It forms the 48-bit mantissa
// product with 24 shift-and-add steps, one multiplier bit per cycle, and
// then spends one cycle normalising, rounding and packing the result.
// Subnormal inputs are not pre-normalised, and results that fall below the
// normal range are flushed to zero.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; returns the block to IDLE at once
//   bus  fp_mul_seq_if.slave
//        - in_valid/in_ready/a/b : operand handshake; in_ready is high only in IDLE
//        - out_valid/out_ready/res/exception/overflow/underflow : result
//          handshake; the result and flags are held while out_ready is low
//        - busy : high while an operation is in progress (MUL, NORM, DONE)
// Every output is driven from a register.
module fp_mul_seq (
  input  logic         clk,
  input  logic         rst,
  fp_mul_seq_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_NORM = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_r;
  logic        sign_r;
  logic        zero_r;
  logic [7:0]  ea_r;
  logic [7:0]  eb_r;
  logic [23:0] ma_r;
  logic [23:0] mb_r;
  logic [47:0] p_r;
  logic [4:0]  cnt_r;

  logic        in_ready_r;
  logic        out_valid_r;
  logic        busy_r;
  logic [31:0] res_r;
  logic        exc_r;
  logic        ovf_r;
  logic        unf_r;

  // Values of the shift-and-add step.
  logic [24:0] add_s;
  logic [47:0] p_next_s;

  // Values of the normalise/round cycle.
  logic        norm_s;
  logic [46:0] pn_s;
  logic        round_s;
  logic [23:0] mant_sum_s;
  logic        carry_s;
  logic [22:0] mant_s;
  logic [9:0]  exp_s;
  logic        exc_cond_s;
  logic        ovf_cond_s;
  logic        unf_cond_s;
  logic [31:0] res_next_s;
  logic        exc_next_s;
  logic        ovf_next_s;
  logic        unf_next_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.res       = res_r;
  assign bus.exception = exc_r;
  assign bus.overflow  = ovf_r;
  assign bus.underflow = unf_r;

  // Shift-and-add step: add the multiplicand into the upper half, then shift
  // the whole accumulator right by one. The carry out becomes the new MSB.
  always_comb begin
    add_s    = 25'd0;
    p_next_s = 48'd0;
    if (mb_r[0]) begin
      add_s = {1'b0, p_r[47:24]} + {1'b0, ma_r};
    end else begin
      add_s = {1'b0, p_r[47:24]};
    end
    p_next_s = {add_s, p_r[23:1]};
  end

  // Normalise, round and pack. The exponent is computed in 10-bit two's
  // complement so that both the overflow and the underflow side can be seen.
  always_comb begin
    norm_s     = p_r[47];
    pn_s       = 47'd0;
    round_s    = 1'b0;
    mant_sum_s = 24'd0;
    carry_s    = 1'b0;
    mant_s     = 23'd0;
    exp_s      = 10'd0;
    exc_cond_s = 1'b0;
    ovf_cond_s = 1'b0;
    unf_cond_s = 1'b0;
    res_next_s = 32'd0;
    exc_next_s = 1'b0;
    ovf_next_s = 1'b0;
    unf_next_s = 1'b0;

    // Bit 47 is the integer bit once the product is normalised, so only
    // bits 46:0 are needed from here on.
    if (norm_s) begin
      pn_s = p_r[46:0];
    end else begin
      pn_s = {p_r[45:0], 1'b0};
    end

    round_s    = pn_s[23] & (|pn_s[22:0]);
    mant_sum_s = {1'b0, pn_s[46:24]} + {23'd0, round_s};
    carry_s    = mant_sum_s[23];
    // A rounding carry out of an all-ones fraction leaves the low bits at
    // zero, which is the fraction wanted for the bumped exponent.
    mant_s     = mant_sum_s[22:0];
    exp_s      = {2'b00, ea_r} + {2'b00, eb_r} - 10'd127
               + {9'd0, norm_s} + {9'd0, carry_s};

    exc_cond_s = (ea_r == 8'hFF) || (eb_r == 8'hFF);
    ovf_cond_s = !exp_s[9] && (exp_s >= 10'd255);
    unf_cond_s = exp_s[9] || (exp_s == 10'd0);

    // The checks are ordered by priority, so the flags are mutually
    // exclusive and a zero result never raises overflow or underflow.
    if (exc_cond_s) begin
      res_next_s = 32'h0000_0000;
      exc_next_s = 1'b1;
    end else if (zero_r) begin
      res_next_s = {sign_r, 31'd0};
    end else if (ovf_cond_s) begin
      res_next_s = {sign_r, 8'hFF, 23'd0};
      ovf_next_s = 1'b1;
    end else if (unf_cond_s) begin
      res_next_s = {sign_r, 31'd0};
      unf_next_s = 1'b1;
    end else begin
      res_next_s = {sign_r, exp_s[7:0], mant_s};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      sign_r      <= 1'b0;
      zero_r      <= 1'b0;
      ea_r        <= 8'd0;
      eb_r        <= 8'd0;
      ma_r        <= 24'd0;
      mb_r        <= 24'd0;
      p_r         <= 48'd0;
      cnt_r       <= 5'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      res_r       <= 32'd0;
      exc_r       <= 1'b0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            sign_r     <= bus.a[31] ^ bus.b[31];
            // The multiplier operand is shifted out during MUL, so the zero
            // test is captured here, while both operands are still whole.
            zero_r     <= ((bus.a[30:23] == 8'd0) && (bus.a[22:0] == 23'd0))
                       || ((bus.b[30:23] == 8'd0) && (bus.b[22:0] == 23'd0));
            ea_r       <= bus.a[30:23];
            eb_r       <= bus.b[30:23];
            ma_r       <= {|bus.a[30:23], bus.a[22:0]};
            mb_r       <= {|bus.b[30:23], bus.b[22:0]};
            p_r        <= 48'd0;
            cnt_r      <= 5'd0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_MUL;
          end
        end
        ST_MUL: begin
          p_r   <= p_next_s;
          mb_r  <= {1'b0, mb_r[23:1]};
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd23) begin
            state_r <= ST_NORM;
          end
        end
        ST_NORM: begin
          res_r       <= res_next_s;
          exc_r       <= exc_next_s;
          ovf_r       <= ovf_next_s;
          unf_r       <= unf_next_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq
// Self-checking bench for fp_mul_seq. It applies a table of directed
// vectors, hand-written handshake and reset sequences, and random operands
// checked against an arithmetic reference model.
module tb_fp_mul_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  fp_mul_seq_if bus ();

  fp_mul_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flags;   // {exception, overflow, underflow}
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer product of the mantissas followed by the
  // result rules, with no shift-and-add sequencing.
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic        s;
    logic [47:0] prod;
    int          m;
    int          e;
    int          nrm;
    int          rnd;
    int          cy;
    ea = a[30:23];
    eb = b[30:23];
    s  = a[31] ^ b[31];
    if (ea == 8'hFF || eb == 8'hFF) return {3'b100, 32'h0};
    if ((ea == 8'd0 && a[22:0] == 23'd0) || (eb == 8'd0 && b[22:0] == 23'd0))
      return {3'b000, s, 31'd0};
    prod = 48'({|ea, a[22:0]}) * 48'({|eb, b[22:0]});
    nrm  = prod[47] ? 1 : 0;
    if (nrm == 0) prod = prod << 1;
    rnd = (prod[23] && prod[22:0] != 23'd0) ? 1 : 0;
    m   = int'(prod[46:24]) + rnd;
    cy  = (m >= (1 << 23)) ? 1 : 0;
    if (cy != 0) m = 0;
    e = int'(ea) + int'(eb) - 127 + nrm + cy;
    if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
    if (e <= 0)   return {3'b001, s, 31'd0};
    return {3'b000, s, e[7:0], m[22:0]};
  endfunction

  // Present one operand pair; it is accepted on the next rising edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  // Count rising edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [2:0] exp_flags);
    int lat;
    start_op(a, b);
    wait_result(lat);
    check({name, "_latency"}, 64'(lat), 64'd25);
    check({name, "_res"}, 64'(bus.res), 64'(exp_res));
    check({name, "_flags"}, 64'({bus.exception, bus.overflow, bus.underflow}), 64'(exp_flags));
    release_result();
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, "_busy"}, 64'(bus.busy), 64'd0);
    check({name, "_res"}, 64'(bus.res), 64'd0);
    check({name, "_flags"}, 64'({bus.exception, bus.overflow, bus.underflow}), 64'd0);
  endtask

  vec_t vecs [0:13];

  initial begin
    logic [34:0] exp_v;
    logic [31:0] ra;
    logic [31:0] rb;
    int          lat;
    int          t_first;
    int          t_second;
    int          cyc;
    int          w;

    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000}; // 2 * 3
    vecs[1]  = '{32'h3FC0_0000, 32'hBFC0_0000, 32'hC010_0000, 3'b000}; // 1.5 * -1.5
    vecs[2]  = '{32'h7F80_0000, 32'h3F80_0000, 32'h0000_0000, 3'b100}; // inf operand
    vecs[3]  = '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 3'b000}; // -0 * 2
    vecs[4]  = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b010}; // overflow
    vecs[5]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b001}; // underflow
    vecs[6]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000}; // 1 * 1
    vecs[7]  = '{32'hBF80_0000, 32'hBF80_0000, 32'h3F80_0000, 3'b000}; // -1 * -1
    vecs[8]  = '{32'h0000_0000, 32'hFF80_0000, 32'h0000_0000, 3'b100}; // exception beats zero
    vecs[9]  = '{32'h6400_0000, 32'h5B00_0000, 32'h7F80_0000, 3'b010}; // E == 255
    vecs[10] = '{32'h6400_0000, 32'h5A80_0000, 32'h7F00_0000, 3'b000}; // E == 254
    vecs[11] = '{32'h1F80_0000, 32'h2000_0000, 32'h0000_0000, 3'b001}; // E == 0
    vecs[12] = '{32'h1F80_0000, 32'h2080_0000, 32'h0080_0000, 3'b000}; // E == 1
    vecs[13] = '{32'h7F00_0000, 32'h0000_0000, 32'h0000_0000, 3'b000}; // zero beats overflow

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags);
    end

    // Backpressure: result held, and in_valid ignored outside IDLE
    start_op(32'h4000_0000, 32'h4040_0000);
    wait_result(lat);
    check("bp_latency", 64'(lat), 64'd25);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a        = 32'h3F80_0000;
      bus.b        = 32'h3F80_0000;
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_res", 64'(bus.res), 64'h40C0_0000);
      check("bp_flags", 64'({bus.exception, bus.overflow, bus.underflow}), 64'd0);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("bp_no_ghost_busy", 64'(bus.busy), 64'd0);

    // Back-to-back with out_ready tied high: 27-cycle spacing
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 32'h3FC0_0000;
    bus.b         = 32'hBFC0_0000;
    t_first  = -1;
    t_second = -1;
    cyc      = 0;
    while (t_second < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        check("b2b_res", 64'(bus.res), 64'hC010_0000);
        if (t_first < 0) t_first = cyc;
        else             t_second = cyc;
      end
    end
    bus.in_valid = 1'b0;
    check("b2b_spacing", 64'(t_second - t_first), 64'd27);
    w = 0;
    while (bus.busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("b2b_drain_busy", 64'(bus.busy), 64'd0);
    bus.out_ready = 1'b0;
    @(negedge clk);

    // Reset during MUL iteration 12
    start_op(32'h4000_0000, 32'h4040_0000);
    repeat (11) @(negedge clk);
    check("midrst_busy_before", 64'(bus.busy), 64'd1);
    #1 rst = 1'b1;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("post_rst");
    do_op("after_rst", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000);

    // Random operands against the reference model
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          ra = $urandom;
          rb = $urandom;
        end
        1, 2: begin
          ra = {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
          rb = {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
        end
        default: begin
          ra = {1'($urandom), 8'($urandom_range(0, 3)), 23'($urandom)};
          rb = {1'($urandom), 8'($urandom_range(250, 255)), 23'($urandom)};
          if ($urandom_range(0, 3) == 0) ra[22:0] = 23'd0;
        end
      endcase
      exp_v = ref_mul(ra, rb);
      do_op($sformatf("rand%0d", i), ra, rb, exp_v[31:0], exp_v[34:32]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
